// File: rtl/irq_controller.sv
// Fixed-priority interrupt controller: latches edge-triggered requests and sequences
// jump/restore pulses to the PC stage. Define IRQ_SYNC_EN to add 2-flop input synchronizers.
module irq_controller #(
    parameter int NUM_IRQ = 4,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               ie_wr_en,
    input  logic [NUM_IRQ:0]   ie_wr_data,
    input  logic               take_ok,
    input  logic               reti,
    output logic               interrupt_jump,
    output logic               interrupt_clear_status,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_IRQ-1:0] pending,
    output logic               in_service
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SERVICE = 2'd1,
        S_RETURN  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [NUM_IRQ-1:0]  r_irq_prev;
    logic [NUM_IRQ:0]    r_ie;
    logic [NUM_IRQ-1:0]  r_pending;
    logic [ID_W-1:0]     r_irq_id;
    logic                r_jump;
    logic                r_clr;

    logic [NUM_IRQ-1:0]  w_irq_src;
    logic [NUM_IRQ-1:0]  w_edge;
    logic [NUM_IRQ-1:0]  w_eligible;
    logic [NUM_IRQ-1:0]  w_clear;
    logic [ID_W-1:0]     w_take_id;
    logic                w_any;
    logic [NUM_IRQ-1:0]  w_pend_next;
    logic [ID_W-1:0]     w_id_next;
    logic                w_jump_next;
    logic                w_clr_next;

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] r_sync1;
    logic [NUM_IRQ-1:0] r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= irq;
            r_sync2 <= r_sync1;
        end
    end

    assign w_irq_src = r_sync2;
`else
    assign w_irq_src = irq;
`endif

    assign w_edge = w_irq_src & ~r_irq_prev;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IRQ; gi++) begin : g_elig
            assign w_eligible[gi] = r_pending[gi] & r_ie[gi] & r_ie[NUM_IRQ];
        end
    endgenerate

    // Scan high-to-low so the lowest eligible index is the last one written.
    always_comb begin
        w_take_id = '0;
        w_clear   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_take_id  = ID_W'(i);
                w_clear    = '0;
                w_clear[i] = 1'b1;
            end
        end
    end

    assign w_any = |w_eligible;

    always_comb begin
        w_state_next = r_state;
        w_jump_next  = 1'b0;
        w_clr_next   = 1'b0;
        w_id_next    = r_irq_id;
        w_pend_next  = r_pending | w_edge;
        case (r_state)
            S_IDLE: begin
                if (take_ok && w_any) begin
                    w_state_next = S_SERVICE;
                    w_jump_next  = 1'b1;
                    w_id_next    = w_take_id;
                    // A fresh edge on the winning line re-arms it.
                    w_pend_next  = (r_pending & ~w_clear) | w_edge;
                end
            end
            S_SERVICE: begin
                if (reti) begin
                    w_state_next = S_RETURN;
                    w_clr_next   = 1'b1;
                end
            end
            S_RETURN: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_irq_prev <= '0;
            r_ie       <= '0;
            r_pending  <= '0;
            r_irq_id   <= '0;
            r_jump     <= 1'b0;
            r_clr      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_irq_prev <= w_irq_src;
            r_pending  <= w_pend_next;
            r_irq_id   <= w_id_next;
            r_jump     <= w_jump_next;
            r_clr      <= w_clr_next;
            if (ie_wr_en) begin
                r_ie <= ie_wr_data;
            end
        end
    end

    assign interrupt_jump         = r_jump;
    assign interrupt_clear_status = r_clr;
    assign irq_id                 = r_irq_id;
    assign pending                = r_pending;
    assign in_service             = (r_state != S_IDLE);

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller (default build, no input synchronizers):
// a vector table for the main flows plus hand-written deferral and reset sequences.
module tb_irq_controller;

    logic       clk;
    logic       rst_n;
    logic [3:0] irq;
    logic       ie_wr_en;
    logic [4:0] ie_wr_data;
    logic       take_ok;
    logic       reti;
    logic       interrupt_jump;
    logic       interrupt_clear_status;
    logic [1:0] irq_id;
    logic [3:0] pending;
    logic       in_service;

    int n_checks;
    int n_errors;

    irq_controller #(.NUM_IRQ(4), .ID_W(2)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .irq                    (irq),
        .ie_wr_en               (ie_wr_en),
        .ie_wr_data             (ie_wr_data),
        .take_ok                (take_ok),
        .reti                   (reti),
        .interrupt_jump         (interrupt_jump),
        .interrupt_clear_status (interrupt_clear_status),
        .irq_id                 (irq_id),
        .pending                (pending),
        .in_service             (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] irq;
        logic       wr_en;
        logic [4:0] wr_data;
        logic       take_ok;
        logic       reti;
        logic       e_jump;
        logic       e_clr;
        logic [1:0] e_id;
        logic [3:0] e_pend;
        logic       e_insvc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [3:0] i, logic w, logic [4:0] d, logic t, logic r,
                                logic j, logic c, logic [1:0] id, logic [3:0] p, logic s);
        vec_t v;
        v.irq = i; v.wr_en = w; v.wr_data = d; v.take_ok = t; v.reti = r;
        v.e_jump = j; v.e_clr = c; v.e_id = id; v.e_pend = p; v.e_insvc = s;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic j, input logic c, input logic [1:0] id,
                             input logic [3:0] p, input logic s);
        chk({tag, ".jump"},  8'(interrupt_jump),         8'(j));
        chk({tag, ".clr"},   8'(interrupt_clear_status), 8'(c));
        chk({tag, ".id"},    8'(irq_id),                 8'(id));
        chk({tag, ".pend"},  8'(pending),                8'(p));
        chk({tag, ".insvc"}, 8'(in_service),             8'(s));
    endtask

    task automatic drive(input logic [3:0] i, input logic w, input logic [4:0] d,
                         input logic t, input logic r);
        @(negedge clk);
        irq = i; ie_wr_en = w; ie_wr_data = d; take_ok = t; reti = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        irq = '0; ie_wr_en = 0; ie_wr_data = '0; take_ok = 0; reti = 0;
        rst_n = 1'b0;
        #1;
        check_all("reset", 0, 0, 2'd0, 4'b0000, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        //          irq     we d         tk rt | jmp clr id  pend    svc
        // single request on line 2
        vecs.push_back(mk(4'b0000, 1, 5'b11111, 1, 0,  0, 0, 2'd0, 4'b0000, 0));
        vecs.push_back(mk(4'b0100, 0, 5'b00000, 1, 0,  0, 0, 2'd0, 4'b0100, 0));
        vecs.push_back(mk(4'b0100, 0, 5'b00000, 1, 0,  1, 0, 2'd2, 4'b0000, 1));
        vecs.push_back(mk(4'b0000, 0, 5'b00000, 1, 0,  0, 0, 2'd2, 4'b0000, 1));
        vecs.push_back(mk(4'b0000, 0, 5'b00000, 1, 1,  0, 1, 2'd2, 4'b0000, 1));
        vecs.push_back(mk(4'b0000, 0, 5'b00000, 1, 0,  0, 0, 2'd2, 4'b0000, 0));
        // lines 3 and 1 together: 1 first, 3 at M+2
        vecs.push_back(mk(4'b1010, 0, 5'b00000, 1, 0,  0, 0, 2'd2, 4'b1010, 0));
        vecs.push_back(mk(4'b0000, 0, 5'b00000, 1, 0,  1, 0, 2'd1, 4'b1000, 1));
        vecs.push_back(mk(4'b0000, 0, 5'b00000, 1, 1,  0, 1, 2'd1, 4'b1000, 1));
        vecs.push_back(mk(4'b0000, 0, 5'b00000, 1, 0,  0, 0, 2'd1, 4'b1000, 0));
        vecs.push_back(mk(4'b0000, 0, 5'b00000, 1, 0,  1, 0, 2'd3, 4'b0000, 1));
        vecs.push_back(mk(4'b0000, 0, 5'b00000, 1, 1,  0, 1, 2'd3, 4'b0000, 1));
        vecs.push_back(mk(4'b0000, 0, 5'b00000, 1, 0,  0, 0, 2'd3, 4'b0000, 0));
        // GIE off: line 0 waits, GIE write takes effect one cycle later
        vecs.push_back(mk(4'b0000, 1, 5'b01111, 1, 0,  0, 0, 2'd3, 4'b0000, 0));
        vecs.push_back(mk(4'b0001, 0, 5'b00000, 1, 0,  0, 0, 2'd3, 4'b0001, 0));
        vecs.push_back(mk(4'b0000, 0, 5'b00000, 1, 0,  0, 0, 2'd3, 4'b0001, 0));
        vecs.push_back(mk(4'b0000, 1, 5'b11111, 1, 0,  0, 0, 2'd3, 4'b0001, 0));
        vecs.push_back(mk(4'b0000, 0, 5'b00000, 1, 0,  1, 0, 2'd0, 4'b0000, 1));
        // line 1 arrives during service of line 0
        vecs.push_back(mk(4'b0010, 0, 5'b00000, 1, 0,  0, 0, 2'd0, 4'b0010, 1));
        vecs.push_back(mk(4'b0000, 0, 5'b00000, 1, 0,  0, 0, 2'd0, 4'b0010, 1));
        vecs.push_back(mk(4'b0000, 0, 5'b00000, 1, 1,  0, 1, 2'd0, 4'b0010, 1));
        vecs.push_back(mk(4'b0000, 0, 5'b00000, 1, 0,  0, 0, 2'd0, 4'b0010, 0));
        vecs.push_back(mk(4'b0000, 0, 5'b00000, 1, 0,  1, 0, 2'd1, 4'b0000, 1));
        vecs.push_back(mk(4'b0000, 0, 5'b00000, 1, 1,  0, 1, 2'd1, 4'b0000, 1));
        vecs.push_back(mk(4'b0000, 0, 5'b00000, 1, 0,  0, 0, 2'd1, 4'b0000, 0));
        // clear and set on the same bit at the take edge: set wins
        vecs.push_back(mk(4'b0100, 0, 5'b00000, 0, 0,  0, 0, 2'd1, 4'b0100, 0));
        vecs.push_back(mk(4'b0000, 0, 5'b00000, 0, 0,  0, 0, 2'd1, 4'b0100, 0));
        vecs.push_back(mk(4'b0100, 0, 5'b00000, 1, 0,  1, 0, 2'd2, 4'b0100, 1));
        vecs.push_back(mk(4'b0000, 0, 5'b00000, 1, 1,  0, 1, 2'd2, 4'b0100, 1));
        vecs.push_back(mk(4'b0000, 0, 5'b00000, 1, 0,  0, 0, 2'd2, 4'b0100, 0));
        vecs.push_back(mk(4'b0000, 0, 5'b00000, 1, 0,  1, 0, 2'd2, 4'b0000, 1));
        vecs.push_back(mk(4'b0000, 0, 5'b00000, 1, 1,  0, 1, 2'd2, 4'b0000, 1));
        vecs.push_back(mk(4'b0000, 0, 5'b00000, 1, 0,  0, 0, 2'd2, 4'b0000, 0));
        // reti in IDLE is ignored
        vecs.push_back(mk(4'b0000, 0, 5'b00000, 1, 1,  0, 0, 2'd2, 4'b0000, 0));
        vecs.push_back(mk(4'b0000, 0, 5'b00000, 1, 0,  0, 0, 2'd2, 4'b0000, 0));

        foreach (vecs[k]) begin
            drive(vecs[k].irq, vecs[k].wr_en, vecs[k].wr_data, vecs[k].take_ok, vecs[k].reti);
            check_all($sformatf("vec%0d", k), vecs[k].e_jump, vecs[k].e_clr,
                      vecs[k].e_id, vecs[k].e_pend, vecs[k].e_insvc);
            $display("vec %0d: irq=%b tk=%b rt=%b -> jmp=%b clr=%b id=%0d pend=%b svc=%b", k,
                     vecs[k].irq, vecs[k].take_ok, vecs[k].reti, interrupt_jump,
                     interrupt_clear_status, irq_id, pending, in_service);
        end

        // take_ok held low for 5 cycles with line 2 eligible
        drive(4'b0100, 0, 5'b00000, 0, 0);
        check_all("defer.set", 0, 0, 2'd2, 4'b0100, 0);
        drive(4'b0000, 0, 5'b00000, 0, 0);
        for (int c = 0; c < 5; c++) begin
            drive(4'b0000, 0, 5'b00000, 0, 0);
            check_all($sformatf("defer.wait%0d", c), 0, 0, 2'd2, 4'b0100, 0);
        end
        drive(4'b0000, 0, 5'b00000, 1, 0);
        check_all("defer.take", 1, 0, 2'd2, 4'b0000, 1);
        $display("defer: jump=%b id=%0d after take_ok rose", interrupt_jump, irq_id);

        // line 3 request, then reset mid-service
        drive(4'b1000, 0, 5'b00000, 1, 0);
        check_all("pre_rst", 0, 0, 2'd2, 4'b1000, 1);
        @(negedge clk);
        irq = 4'b0000;
        #2;
        rst_n = 1'b0;
        #1;
        check_all("rst_async", 0, 0, 2'd0, 4'b0000, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b0000, 0, 5'b00000, 1, 1);
        check_all("rst.reti", 0, 0, 2'd0, 4'b0000, 0);
        drive(4'b0000, 0, 5'b00000, 1, 0);
        check_all("rst.after", 0, 0, 2'd0, 4'b0000, 0);
        // enable register was cleared: a new request stays pending
        drive(4'b0001, 0, 5'b00000, 1, 0);
        drive(4'b0000, 0, 5'b00000, 1, 0);
        check_all("rst.ie_off", 0, 0, 2'd0, 4'b0001, 0);
        $display("reset: jump=%b clr=%b pend=%b svc=%b", interrupt_jump,
                 interrupt_clear_status, pending, in_service);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
# irq_controller

Interrupt controller directly upstream of the instruction ROM/PC stage. It latches external interrupt requests, applies per-line enables and a global enable, and arbitrates by fixed priority. It issues the single-cycle `interrupt_jump` and `interrupt_clear_status` pulses that make the PC stage save, vector and restore the PC. One interrupt is in service at a time; nesting is not supported.

## Interface
Parameters:
- `NUM_IRQ`, default 4: number of request lines, 1..8.
- `ID_W`, default 2: width of `irq_id`. Must satisfy 2^ID_W ≥ NUM_IRQ.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `irq`, input, NUM_IRQ: request lines, rising-edge triggered.
- `ie_wr_en`, input, 1: write strobe for the enable register.
- `ie_wr_data`, input, NUM_IRQ+1: bit NUM_IRQ is the global enable (GIE); bits NUM_IRQ-1:0 are the per-line enables.
- `take_ok`, input, 1: core is at an instruction boundary with no `jump_enable` in flight.
- `reti`, input, 1: decoder has retired a return-from-interrupt instruction.
- `interrupt_jump`, output, 1: registered one-cycle pulse to the PC stage.
- `interrupt_clear_status`, output, 1: registered one-cycle pulse to the PC stage.
- `irq_id`, output, ID_W: index of the line being serviced.
- `pending`, output, NUM_IRQ: latched requests.
- `in_service`, output, 1: high while state is not IDLE.

## Operation
- Edge detect: `irq_prev` register. A bit is detected when irq=1 and irq_prev=0 at a clock edge; that edge sets the corresponding `pending` bit.
- Pending bits latch regardless of the enable register. Disabled lines stay pending until they are enabled and taken.
- A line is eligible when pending AND its enable bit is set AND GIE=1.
- Priority is fixed: the lowest index wins.
- The state machine has three states: IDLE, SERVICE, RETURN.
- IDLE → SERVICE on an edge where an eligible line exists and `take_ok`=1. On that edge:
  - `interrupt_jump`←1.
  - `irq_id`←the winning index.
  - `pending[winner]`←0.
- SERVICE → RETURN on an edge with `reti`=1. On that edge `interrupt_clear_status`←1.
- RETURN → IDLE unconditionally on the next edge. No new take is allowed in RETURN, so the PC restore completes first.
- Both pulse outputs return to 0 on the edge after they were set.
- `reti` is ignored in IDLE and RETURN.
- In SERVICE, new edges still set `pending`; they are taken only after returning to IDLE.
- Simultaneous clear and set on the same bit: set wins. The bit stays pending and is re-serviced later.
- `ie_wr_en` updates the enable register on the edge and affects eligibility from the next cycle onward. Clearing GIE in SERVICE does not abort the service.
- `irq_id` holds its value through SERVICE and RETURN and keeps the last value while in IDLE.

## Timing
- Reset (asynchronous assert, released synchronously by the clock domain) clears the following. Reset mid-service abandons the service without a `interrupt_clear_status` pulse.
  - state=IDLE.
  - All outputs=0.
  - `pending`=0, `irq_prev`=0, enable register=0 (GIE off).
- Request latency, with `take_ok`=1 and the line enabled:
  - Edge N samples the irq rising edge and sets `pending`.
  - Edge N+1 sets `interrupt_jump`.
  - The PC stage vectors at edge N+2.
- Return latency: `reti` sampled at edge M sets `interrupt_clear_status` at M, high during cycle M..M+1. State is IDLE after M+1. The earliest next take is edge M+2.
- If `take_ok`=0, the take is deferred cycle by cycle with no loss of pending state.

## Configuration
- `IRQ_SYNC_EN`: when defined, each `irq` bit passes through a two-flop synchronizer before edge detection. This adds 2 cycles to request latency: the first take is at edge N+3 after the input edge. Synchronizer flops reset to 0.
- When undefined, `irq` is assumed synchronous to `clk` and feeds edge detection directly.

## Test plan
- Reset, then GIE+IE=all ones, then pulse irq[2]: `pending`=0b0100 after one edge. `interrupt_jump` pulses for one cycle on the next edge, `irq_id`=2, `pending`=0, `in_service`=1.
- irq[3] and irq[1] rise on the same edge: irq[1] is serviced first. After `reti` and RETURN, irq[3] is taken at the earliest edge M+2.
- irq[0] rises while GIE=0: it stays pending and there is no jump. Writing GIE=1 produces a jump one cycle later with `irq_id`=0.
- irq[1] rises while in SERVICE for irq[0]: no jump until `reti`. `interrupt_clear_status` pulses for one cycle, then irq[1] is taken.
- Hold `take_ok`=0 with irq[2] eligible for 5 cycles: no jump. The jump occurs on the first edge with `take_ok`=1.
- Assert `rst_n`=0 mid-SERVICE: all outputs are 0 immediately and state is IDLE. A later `reti` produces no pulse.
